// File: rtl/fmdll_cfg_ctrl_if.sv
// ---------------------------------------------------------------------------
// fmdll_cfg_ctrl_if
// Configuration request channel into the DLL configuration/lock sequencer.
//   cfg_valid : requester has an M/N ratio request
//   cfg_ready : sequencer can accept a request this cycle
//   cfg_m     : requested M (2 bits)
//   cfg_n     : requested N (4 bits)
// Modports:
//   master : requester side (drives valid/m/n, observes ready)
//   slave  : sequencer side (observes valid/m/n, drives ready)
// ---------------------------------------------------------------------------
interface fmdll_cfg_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_m;
  logic [3:0] cfg_n;

  modport master (
    output cfg_valid,
    output cfg_m,
    output cfg_n,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_m,
    input  cfg_n,
    output cfg_ready
  );
endinterface

// File: rtl/fmdll_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// fmdll_cfg_ctrl
// Configuration and lock sequencer for the frequency-multiplying DLL.
// Accepts M/N ratio requests, rejects illegal ratios, drives the DLL's M, N
// and active-low reset, waits a settle interval and then declares lock once
// the DLL's 2-bit Sel band output has been constant for LOCK_CYC cycles.
// Runs entirely on the reference clock clk_ext.
//
// Ports:
//   clk_ext    in  1 : reference clock (only clock)
//   rst        in  1 : asynchronous active-high reset
//   cfg        slave : request channel (cfg_valid/cfg_ready/cfg_m/cfg_n)
//   sel_in     in  2 : DLL Sel output, asynchronous, synchronized here
//   dll_m      out 2 : M driven to the DLL
//   dll_n      out 4 : N driven to the DLL
//   dll_rst_n  out 1 : DLL reset, active low
//   locked     out 1 : DLL locked at current dll_m/dll_n
//   cfg_err    out 1 : one-cycle pulse on rejected (illegal) request
//   timeout    out 1 : sticky lock-failure flag
//   lock_lost  out 1 : one-cycle pulse when lock drops
// ---------------------------------------------------------------------------
module fmdll_cfg_ctrl #(
  parameter int RST_CYC     = 4,
  parameter int SETTLE_CYC  = 64,
  parameter int LOCK_CYC    = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic             clk_ext,
  input  logic             rst,
  fmdll_cfg_ctrl_if.slave  cfg,
  input  logic [1:0]       sel_in,
  output logic [1:0]       dll_m,
  output logic [3:0]       dll_n,
  output logic             dll_rst_n,
  output logic             locked,
  output logic             cfg_err,
  output logic             timeout,
  output logic             lock_lost
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_SETTLE = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  // Terminal counts: a counter holding *_LAST on an edge completes the interval.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

  // Legal ratios: M in {1,2,3}, N in {1,4,5,8,10}.
  function automatic logic is_legal(input logic [1:0] m, input logic [3:0] n);
    logic n_ok;
    case (n)
      4'd1, 4'd4, 4'd5, 4'd8, 4'd10: n_ok = 1'b1;
      default:                       n_ok = 1'b0;
    endcase
    return (m != 2'd0) && n_ok;
  endfunction

  // State and counters
  state_t           state_r, state_n;
  logic [CNT_W-1:0] phase_cnt_r, phase_cnt_n;   // RESET / SETTLE interval counter
  logic [CNT_W-1:0] stable_cnt_r, stable_cnt_n; // consecutive unchanged-Sel cycles
  logic [CNT_W-1:0] to_cnt_r, to_cnt_n;         // cycles spent in TRACK
  // Cleared by rst; makes the first edge after rst release play the role of
  // the accept edge, so power-up and reconfiguration share one timeline.
  logic             started_r;

  // Sel synchronizer and history
  logic [1:0] sel_meta_r, sel_sync_r, sel_prev_r;

  // Registered outputs and their next values
  logic [1:0] dll_m_r, dll_m_n;
  logic [3:0] dll_n_r, dll_n_n;
  logic       dll_rst_n_r, dll_rst_n_n;
  logic       locked_r, locked_n;
  logic       cfg_ready_r, cfg_ready_n;
  logic       cfg_err_r, cfg_err_n;
  logic       timeout_r, timeout_n;
  logic       lock_lost_r, lock_lost_n;

  logic accept_s;
  logic legal_s;
  logic sel_chg_s;

  assign accept_s  = cfg.cfg_valid && cfg_ready_r;
  assign legal_s   = is_legal(cfg.cfg_m, cfg.cfg_n);
  assign sel_chg_s = (sel_sync_r != sel_prev_r);

  // Next-state, counter and output computation
  always_comb begin
    state_n      = state_r;
    phase_cnt_n  = phase_cnt_r;
    stable_cnt_n = stable_cnt_r;
    to_cnt_n     = to_cnt_r;
    dll_m_n      = dll_m_r;
    dll_n_n      = dll_n_r;
    timeout_n    = timeout_r;
    cfg_err_n    = 1'b0;
    lock_lost_n  = 1'b0;

    if (accept_s && legal_s) begin
      // A legal request restarts the whole bring-up from RESET.
      dll_m_n     = cfg.cfg_m;
      dll_n_n     = cfg.cfg_n;
      timeout_n   = 1'b0;
      state_n     = ST_RESET;
      phase_cnt_n = CNT_ZERO;
    end else if (accept_s) begin
      // Rejected request: report it and leave everything else alone. This
      // also outranks a simultaneous Sel change while LOCKED.
      cfg_err_n = 1'b1;
    end else begin
      case (state_r)
        ST_RESET: begin
          if (!started_r) begin
            phase_cnt_n = CNT_ZERO;
          end else if (phase_cnt_r == RST_LAST) begin
            state_n     = ST_SETTLE;
            phase_cnt_n = CNT_ZERO;
          end else begin
            phase_cnt_n = phase_cnt_r + CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (phase_cnt_r == SETTLE_LAST) begin
            state_n      = ST_TRACK;
            phase_cnt_n  = CNT_ZERO;
            stable_cnt_n = CNT_ZERO;
            to_cnt_n     = CNT_ZERO;
          end else begin
            phase_cnt_n = phase_cnt_r + CNT_ONE;
          end
        end
        ST_TRACK: begin
          if (sel_chg_s) begin
            stable_cnt_n = CNT_ZERO;
          end else begin
            stable_cnt_n = stable_cnt_r + CNT_ONE;
          end
          to_cnt_n = to_cnt_r + CNT_ONE;
          // Lock is checked first so it wins a tie with the timeout.
          if (!sel_chg_s && (stable_cnt_r == LOCK_LAST)) begin
            state_n = ST_LOCKED;
          end else if (to_cnt_r == TO_LAST) begin
            state_n   = ST_FAIL;
            timeout_n = 1'b1;
          end else begin
            state_n = ST_TRACK;
          end
        end
        ST_LOCKED: begin
          if (sel_chg_s) begin
            // Re-track without re-pulsing the DLL reset.
            state_n      = ST_TRACK;
            stable_cnt_n = CNT_ZERO;
            to_cnt_n     = CNT_ZERO;
            lock_lost_n  = 1'b1;
          end else begin
            state_n = ST_LOCKED;
          end
        end
        ST_FAIL: begin
          state_n = ST_FAIL;
        end
        default: begin
          // Unreachable encoding: restart the bring-up from a safe state.
          state_n     = ST_RESET;
          phase_cnt_n = CNT_ZERO;
        end
      endcase
    end

    dll_rst_n_n = (state_n != ST_RESET);
    locked_n    = (state_n == ST_LOCKED);
    cfg_ready_n = (state_n == ST_LOCKED) || (state_n == ST_FAIL);
  end

  // FSM state register
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      state_r <= ST_RESET;
    end else begin
      state_r <= state_n;
    end
  end

  // Interval, stability and timeout counters
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      phase_cnt_r  <= CNT_ZERO;
      stable_cnt_r <= CNT_ZERO;
      to_cnt_r     <= CNT_ZERO;
      started_r    <= 1'b0;
    end else begin
      phase_cnt_r  <= phase_cnt_n;
      stable_cnt_r <= stable_cnt_n;
      to_cnt_r     <= to_cnt_n;
      started_r    <= 1'b1;
    end
  end

  // Two-flop Sel synchronizer plus one history stage for change detection
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      sel_meta_r <= 2'd0;
      sel_sync_r <= 2'd0;
      sel_prev_r <= 2'd0;
    end else begin
      sel_meta_r <= sel_in;
      sel_sync_r <= sel_meta_r;
      sel_prev_r <= sel_sync_r;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      dll_m_r     <= 2'd1;
      dll_n_r     <= 4'd1;
      dll_rst_n_r <= 1'b0;
      locked_r    <= 1'b0;
      cfg_ready_r <= 1'b0;
      cfg_err_r   <= 1'b0;
      timeout_r   <= 1'b0;
      lock_lost_r <= 1'b0;
    end else begin
      dll_m_r     <= dll_m_n;
      dll_n_r     <= dll_n_n;
      dll_rst_n_r <= dll_rst_n_n;
      locked_r    <= locked_n;
      cfg_ready_r <= cfg_ready_n;
      cfg_err_r   <= cfg_err_n;
      timeout_r   <= timeout_n;
      lock_lost_r <= lock_lost_n;
    end
  end

  assign cfg.cfg_ready = cfg_ready_r;
  assign dll_m         = dll_m_r;
  assign dll_n         = dll_n_r;
  assign dll_rst_n     = dll_rst_n_r;
  assign locked        = locked_r;
  assign cfg_err       = cfg_err_r;
  assign timeout       = timeout_r;
  assign lock_lost     = lock_lost_r;

endmodule

// File: tb/tb_fmdll_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fmdll_cfg_ctrl
// Directed bench for fmdll_cfg_ctrl with default parameters
// (RST 4, SETTLE 64, LOCK 32, TIMEOUT 1024). Outputs are sampled 1 ns after
// each rising edge; inputs are changed at the same point.
// ---------------------------------------------------------------------------
module tb_fmdll_cfg_ctrl;

  logic       clk_ext;
  logic       rst;
  logic [1:0] sel_in;
  logic [1:0] dll_m;
  logic [3:0] dll_n;
  logic       dll_rst_n;
  logic       locked;
  logic       cfg_err;
  logic       timeout;
  logic       lock_lost;

  int total;
  int bad;

  fmdll_cfg_ctrl_if cfg_if ();

  fmdll_cfg_ctrl dut (
    .clk_ext   (clk_ext),
    .rst       (rst),
    .cfg       (cfg_if),
    .sel_in    (sel_in),
    .dll_m     (dll_m),
    .dll_n     (dll_n),
    .dll_rst_n (dll_rst_n),
    .locked    (locked),
    .cfg_err   (cfg_err),
    .timeout   (timeout),
    .lock_lost (lock_lost)
  );

  initial clk_ext = 1'b0;
  always #5 clk_ext = ~clk_ext;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the sampling point.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_ext);
      #1;
    end
  endtask

  // Bring-up timeline; the next edge is edge k (accept or first after rst).
  task automatic timeline(input string tag, input logic [1:0] em, input logic [3:0] en);
    step(1);                                   // edge k
    cfg_if.cfg_valid = 1'b0;
    chk({tag, "_rstn_k"},    dll_rst_n, 1'b0);
    chk({tag, "_m_k"},       dll_m, em);
    chk({tag, "_n_k"},       dll_n, en);
    chk({tag, "_locked_k"},  locked, 1'b0);
    chk({tag, "_ready_k"},   cfg_if.cfg_ready, 1'b0);
    step(3);                                   // k+3
    chk({tag, "_rstn_k3"},   dll_rst_n, 1'b0);
    step(1);                                   // k+4
    chk({tag, "_rstn_k4"},   dll_rst_n, 1'b1);
    step(95);                                  // k+99
    chk({tag, "_locked_k99"}, locked, 1'b0);
    chk({tag, "_ready_k99"},  cfg_if.cfg_ready, 1'b0);
    step(1);                                   // k+100
    chk({tag, "_locked_k100"}, locked, 1'b1);
    chk({tag, "_ready_k100"},  cfg_if.cfg_ready, 1'b1);
    chk({tag, "_m_k100"},      dll_m, em);
    chk({tag, "_n_k100"},      dll_n, en);
  endtask

  initial begin
    int rstn_low;
    total = 0;
    bad   = 0;
    rst              = 1'b1;
    sel_in           = 2'd2;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_m     = 2'd0;
    cfg_if.cfg_n     = 4'd0;

    // Reset values
    step(2);
    chk("rst_m",       dll_m, 2'd1);
    chk("rst_n",       dll_n, 4'd1);
    chk("rst_rstn",    dll_rst_n, 1'b0);
    chk("rst_ready",   cfg_if.cfg_ready, 1'b0);
    chk("rst_locked",  locked, 1'b0);
    chk("rst_err",     cfg_err, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_lost",    lock_lost, 1'b0);

    // Power-up
    rst = 1'b0;
    timeline("pwr", 2'd1, 4'd1);

    // Legal reconfiguration M=3 N=10
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_m     = 2'd3;
    cfg_if.cfg_n     = 4'd10;
    timeline("cfg", 2'd3, 4'd10);

    // Illegal request M=0 N=10
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_m     = 2'd0;
    cfg_if.cfg_n     = 4'd10;
    step(1);
    cfg_if.cfg_valid = 1'b0;
    chk("ill0_err",    cfg_err, 1'b1);
    chk("ill0_m",      dll_m, 2'd3);
    chk("ill0_n",      dll_n, 4'd10);
    chk("ill0_locked", locked, 1'b1);
    chk("ill0_rstn",   dll_rst_n, 1'b1);
    step(1);
    chk("ill0_err_end", cfg_err, 1'b0);

    // Illegal request M=2 N=6
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_m     = 2'd2;
    cfg_if.cfg_n     = 4'd6;
    step(1);
    cfg_if.cfg_valid = 1'b0;
    chk("ill1_err",    cfg_err, 1'b1);
    chk("ill1_m",      dll_m, 2'd3);
    chk("ill1_n",      dll_n, 4'd10);
    chk("ill1_locked", locked, 1'b1);
    chk("ill1_ready",  cfg_if.cfg_ready, 1'b1);
    step(1);
    chk("ill1_err_end", cfg_err, 1'b0);

    // Lock loss: Sel 2 -> 3 once
    sel_in = 2'd3;
    step(2);
    chk("loss_locked_e2", locked, 1'b1);
    chk("loss_lost_e2",   lock_lost, 1'b0);
    step(1);
    chk("loss_locked_e3", locked, 1'b0);
    chk("loss_lost_e3",   lock_lost, 1'b1);
    chk("loss_ready_e3",  cfg_if.cfg_ready, 1'b0);
    rstn_low = 0;
    for (int i = 1; i <= 31; i++) begin
      step(1);
      if (dll_rst_n !== 1'b1) rstn_low++;
      if (i == 1) chk("loss_lost_end", lock_lost, 1'b0);
    end
    chk("loss_locked_e34", locked, 1'b0);
    step(1);
    if (dll_rst_n !== 1'b1) rstn_low++;
    chk("loss_relock_e35", locked, 1'b1);
    chk("loss_no_rstn",    rstn_low, 0);
    chk("loss_m_kept",     dll_m, 2'd3);

    // Timeout: legal M=1 N=4, then Sel toggles every 10 cycles
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_m     = 2'd1;
    cfg_if.cfg_n     = 4'd4;
    step(1);                                   // edge k
    cfg_if.cfg_valid = 1'b0;
    chk("to_m", dll_m, 2'd1);
    chk("to_n", dll_n, 4'd4);
    for (int i = 1; i <= 1092; i++) begin
      if ((i % 10) == 0) sel_in = sel_in ^ 2'b01;
      step(1);                                 // edge k+i
      if (i == 1091) begin
        chk("to_flag_pre",  timeout, 1'b0);
        chk("to_ready_pre", cfg_if.cfg_ready, 1'b0);
      end
    end
    chk("to_flag",   timeout, 1'b1);
    chk("to_ready",  cfg_if.cfg_ready, 1'b1);
    chk("to_locked", locked, 1'b0);
    step(5);
    chk("to_sticky", timeout, 1'b1);

    // Following legal request M=2 N=8 clears timeout
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_m     = 2'd2;
    cfg_if.cfg_n     = 4'd8;
    step(1);
    chk("clr_timeout", timeout, 1'b0);
    chk("clr_m",       dll_m, 2'd2);
    chk("clr_n",       dll_n, 4'd8);
    chk("clr_rstn",    dll_rst_n, 1'b0);
    chk("clr_ready",   cfg_if.cfg_ready, 1'b0);
    // Request while not ready is ignored
    cfg_if.cfg_m = 2'd0;
    step(1);
    cfg_if.cfg_valid = 1'b0;
    chk("nrdy_err", cfg_err, 1'b0);
    chk("nrdy_m",   dll_m, 2'd2);

    // Reset mid-SETTLE
    step(10);
    chk("mid_rstn_settle", dll_rst_n, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_m",      dll_m, 2'd1);
    chk("mid_n",      dll_n, 4'd1);
    chk("mid_rstn",   dll_rst_n, 1'b0);
    chk("mid_ready",  cfg_if.cfg_ready, 1'b0);
    chk("mid_locked", locked, 1'b0);
    chk("mid_timeout", timeout, 1'b0);
    step(2);
    rst = 1'b0;
    timeline("rep", 2'd1, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmdll_cfg_ctrl.md
# fmdll_cfg_ctrl

Configuration and lock sequencer that sits directly upstream of the frequency-multiplying DLL.
- Accepts M/N ratio requests over a valid/ready handshake and rejects illegal ratios.
- Drives the DLL's M, N and active-low reset, then waits a settle interval.
- Declares lock once the DLL's 2-bit `Sel` band output stays constant for a programmable window.
- Runs entirely on the external reference clock and is the only agent that reconfigures the DLL.

## Interface
- `RST_CYC`, 4: cycles `dll_rst_n` is held low per configuration.
- `SETTLE_CYC`, 64: cycles after DLL reset release before lock tracking starts.
- `LOCK_CYC`, 32: consecutive stable-`Sel` cycles required for lock.
- `TIMEOUT_CYC`, 1024: maximum TRACK cycles before declaring failure.
- `CNT_W`, 11: internal counter width; must hold the largest of the above.

Ports:
- `clk_ext` in 1: reference clock, the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: configuration request.
- `cfg_ready` out 1: request can be accepted.
- `cfg_m` in 2: requested M.
- `cfg_n` in 4: requested N.
- `sel_in` in 2: DLL `Sel` output. Asynchronous to this block; synchronized internally.
- `dll_m` out 2: M driven to the DLL.
- `dll_n` out 4: N driven to the DLL.
- `dll_rst_n` out 1: DLL reset, active low.
- `locked` out 1: DLL locked at current `dll_m`/`dll_n`.
- `cfg_err` out 1: one-cycle pulse when an illegal request is rejected.
- `timeout` out 1: sticky failure flag.
- `lock_lost` out 1: one-cycle pulse when lock drops.

## Operation
- States: RESET, SETTLE, TRACK, LOCKED, FAIL.
- Legal requests: `cfg_m` ∈ {1,2,3} and `cfg_n` ∈ {1,4,5,8,10}. Every other value is illegal.
- **Reset values:**
  - State RESET, counter 0.
  - `dll_m`=1, `dll_n`=1, `dll_rst_n`=0.
  - `cfg_ready`=0, `locked`=0, `cfg_err`=0, `timeout`=0, `lock_lost`=0.
  - Sync flops = 0.
- **RESET:** `dll_rst_n`=0 for `RST_CYC` cycles, then go to SETTLE.
- **SETTLE:** `dll_rst_n`=1; count `SETTLE_CYC` cycles, then go to TRACK.
  - Entering TRACK clears the stable counter and the timeout counter.
- **TRACK:**
  - `sel_in` passes through a 2-flop synchronizer to give `sel_s`.
  - Each cycle `sel_s` equals its previous value, the stable counter increments. Any change clears it to 0.
  - When the stable counter reaches `LOCK_CYC`: go to LOCKED and set `locked`=1.
  - Otherwise, when the timeout counter reaches `TIMEOUT_CYC`: go to FAIL and set `timeout`=1.
  - If both conditions occur in the same cycle, lock wins.
- **LOCKED:**
  - Any `sel_s` change: `locked`→0, `lock_lost` pulses, return to TRACK with counters cleared. `dll_rst_n` is not re-pulsed.
- **FAIL:** hold until a new request is accepted.
- **Handshake:**
  - `cfg_ready`=1 only in LOCKED and FAIL.
  - A request is accepted on an edge where `cfg_valid`&&`cfg_ready`.
- **Legal accept:**
  - `dll_m`/`dll_n` load the request.
  - `dll_rst_n`→0, `locked`→0, `timeout`→0, `cfg_ready`→0.
  - State → RESET with counter cleared.
- **Illegal accept:** `cfg_err` pulses for 1 cycle; all other outputs and the state are unchanged.
- **Simultaneous accept and `sel_s` change in LOCKED:** the accept takes priority and `lock_lost` does not pulse.
- **`cfg_valid` while `cfg_ready`=0:** ignored; the request is not queued.
- **`rst` asserted mid-operation:** immediately restores all reset values, including `dll_m`/`dll_n`=1, regardless of state.

## Timing
- All outputs are registered.
- `dll_m`, `dll_n`, `dll_rst_n`, `cfg_ready` and `locked` change only on `clk_ext` rising edges. `rst` is the only exception.
- Legal accept at edge k:
  - `dll_rst_n` low from k to k+`RST_CYC`.
  - TRACK is entered at k+`RST_CYC`+`SETTLE_CYC`.
  - With a constant `sel_in`, `locked` rises at edge k+`RST_CYC`+`SETTLE_CYC`+`LOCK_CYC`, and `cfg_ready` rises on that same edge.
- After `rst` deasserts, the same timeline applies, with k being the first edge after deassertion.
- `timeout` rises `TIMEOUT_CYC` cycles after TRACK entry if lock has not been reached.
- A `sel_in` change reaches `sel_s` after 2 edges, so in LOCKED `locked` falls 3 edges after the change.
- `dll_m` and `dll_n` are never changed while `dll_rst_n`=1.

## Test plan
- **Power-up:** release `rst`, hold `sel_in`=2.
  - `dll_rst_n` low for 4 cycles.
  - `locked` rises at cycle 100, with `dll_m`=1, `dll_n`=1 and `cfg_ready`=1.
- **Legal reconfiguration:** from LOCKED, request M=3 N=10.
  - `dll_m`=3, `dll_n`=10.
  - `dll_rst_n` pulses low for 4 cycles.
  - `locked` drops immediately and rises 100 cycles after the accept.
- **Illegal request:** request M=0 N=10 or M=2 N=6.
  - `cfg_err` is a single-cycle pulse.
  - `dll_m`/`dll_n` and `locked` are unchanged.
- **Timeout:** toggle `sel_in` every 10 cycles throughout TRACK.
  - `timeout`=1 at TRACK+1024 and `cfg_ready`=1.
  - A following legal request clears `timeout`.
- **Lock loss:** in LOCKED, change `sel_in` 2→3 once.
  - `lock_lost` pulses and `locked` falls 3 edges later.
  - `locked` re-rises after 32 stable cycles, with no `dll_rst_n` pulse.
- **Reset mid-SETTLE:** after a legal M=2 N=8 accept, assert `rst` during SETTLE.
  - Outputs return to reset values immediately, including `dll_m`=1 and `dll_n`=1.
  - The power-up timeline then repeats.
